// File: rtl/traffic_ctrl_if.sv
// Light-controller <-> timer/sensor bundle; master is the FSM, slave the timer/sensor side.
interface traffic_ctrl_if;
    logic       car;
    logic       long_to;
    logic       short_to;
    logic       tmr_sel;
    logic       tmr_start;
    logic [1:0] hwy_light;
    logic [1:0] farm_light;
    logic [2:0] state_dbg;

    modport master (
        input  car,
        input  long_to,
        input  short_to,
        output tmr_sel,
        output tmr_start,
        output hwy_light,
        output farm_light,
        output state_dbg
    );

    modport slave (
        output car,
        output long_to,
        output short_to,
        input  tmr_sel,
        input  tmr_start,
        input  hwy_light,
        input  farm_light,
        input  state_dbg
    );
endinterface

// File: rtl/traffic_ctrl_fsm.sv
// Highway/farm-road light sequencer closing the loop with the interval timer, with a counted all-red gap.
// Latency: outputs registered, one edge after the deciding input; no backpressure, timeouts are one-cycle pulses.
module traffic_ctrl_fsm #(
    parameter int               CNT_W      = 26,
    parameter logic [CNT_W-1:0] ALLRED_CYC = 26'd24_999_999
) (
    input  logic                  clk,
    input  logic                  rst_n,
    traffic_ctrl_if.master        bus
);

    typedef enum logic [2:0] {
        HG  = 3'd0,
        HY  = 3'd1,
        AR1 = 3'd2,
        FG  = 3'd3,
        FY  = 3'd4,
        AR2 = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] clr_cnt_q, clr_cnt_d;
    logic             car_meta_q, car_s_q;
    logic             req_q, req_d;
    logic             pending_start_q;
    logic             tmr_sel_q, tmr_sel_d;
    logic             tmr_start_q, tmr_start_d;
    logic [1:0]       hwy_q, hwy_d;
    logic [1:0]       farm_q, farm_d;
    logic             rearm;
    logic             entering;
    logic             clr_done;

    assign clr_done = (clr_cnt_q == ALLRED_CYC);

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = '0;
        rearm     = 1'b0;
        case (state_q)
            HG: begin
                if (bus.long_to) begin
                    if (req_q) state_d = HY;
                    else       rearm   = 1'b1;
                end
            end
            HY: if (bus.short_to) state_d = AR1;
            AR1: begin
                if (clr_done) state_d   = FG;
                else          clr_cnt_d = clr_cnt_q + CNT_W'(1);
            end
            FG: if (bus.long_to)  state_d = FY;
            FY: if (bus.short_to) state_d = AR2;
            AR2: begin
                if (clr_done) state_d   = HG;
                else          clr_cnt_d = clr_cnt_q + CNT_W'(1);
            end
            default: state_d = HG;
        endcase

        // All-red states never restart the timer; it is only re-armed on a lit state entry.
        entering    = (state_d != state_q) &&
                      (state_d == HG || state_d == HY || state_d == FG || state_d == FY);
        tmr_start_d = pending_start_q | entering | rearm;
        tmr_sel_d   = tmr_start_d ? (state_d == HY || state_d == FY) : tmr_sel_q;

        // Clearing on farm-green entry takes priority over a simultaneous sensor hit.
        if (state_d == FG && state_q != FG)     req_d = 1'b0;
        else if (car_s_q && state_q != FG)      req_d = 1'b1;
        else                                    req_d = req_q;

        hwy_d  = 2'b00;
        farm_d = 2'b00;
        case (state_d)
            HG:      hwy_d  = 2'b10;
            HY:      hwy_d  = 2'b01;
            FG:      farm_d = 2'b10;
            FY:      farm_d = 2'b01;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= HG;
            clr_cnt_q       <= '0;
            car_meta_q      <= 1'b0;
            car_s_q         <= 1'b0;
            req_q           <= 1'b0;
            pending_start_q <= 1'b1;
            tmr_sel_q       <= 1'b0;
            tmr_start_q     <= 1'b0;
            hwy_q           <= 2'b10;
            farm_q          <= 2'b00;
        end else begin
            state_q         <= state_d;
            clr_cnt_q       <= clr_cnt_d;
            car_meta_q      <= bus.car;
            car_s_q         <= car_meta_q;
            req_q           <= req_d;
            pending_start_q <= 1'b0;
            tmr_sel_q       <= tmr_sel_d;
            tmr_start_q     <= tmr_start_d;
            hwy_q           <= hwy_d;
            farm_q          <= farm_d;
        end
    end

    assign bus.tmr_sel    = tmr_sel_q;
    assign bus.tmr_start  = tmr_start_q;
    assign bus.hwy_light  = hwy_q;
    assign bus.farm_light = farm_q;
    assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_traffic_ctrl_fsm.sv
// Directed walk through the light sequence followed by random traffic, checked against a phase-level model.
module tb_traffic_ctrl_fsm;

    localparam int ALLRED = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    traffic_ctrl_if bus ();

    traffic_ctrl_fsm #(
        .CNT_W      (26),
        .ALLRED_CYC (26'd3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Phase model: 0 HG, 1 HY, 2 AR1, 3 FG, 4 FY, 5 AR2
    int hwy_tab  [6] = '{2, 1, 0, 0, 0, 0};
    int farm_tab [6] = '{0, 0, 0, 2, 1, 0};
    int m_phase   = 0;
    int m_gap     = 0;
    bit m_req     = 0;
    bit m_pending = 1;
    bit m_start   = 0;
    bit m_sel     = 0;
    bit car_hist [$] = '{0, 0};

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rs, input bit c, input bit lt, input bit st);
        int  nxt;
        bit  rearm;
        bit  car_s;
        if (!rs) begin
            m_phase = 0; m_gap = 0; m_req = 0; m_pending = 1; m_start = 0; m_sel = 0;
            car_hist = '{0, 0};
            return;
        end
        car_s = car_hist[1];
        nxt   = m_phase;
        rearm = 0;
        if (m_phase == 0 && lt) begin
            if (m_req) nxt = 1; else rearm = 1;
        end else if ((m_phase == 1 || m_phase == 4) && st) begin
            nxt   = m_phase + 1;
            m_gap = ALLRED + 1;
        end else if (m_phase == 3 && lt) begin
            nxt = 4;
        end else if (m_phase == 2 || m_phase == 5) begin
            m_gap--;
            if (m_gap == 0) nxt = (m_phase == 2) ? 3 : 0;
        end
        if (nxt == 3 && m_phase != 3)       m_req = 0;
        else if (car_s && m_phase != 3)     m_req = 1;
        m_start = m_pending || rearm || (nxt != m_phase && nxt != 2 && nxt != 5);
        if (m_start) m_sel = (nxt == 1 || nxt == 4);
        m_pending = 0;
        m_phase   = nxt;
        void'(car_hist.pop_back());
        car_hist.push_front(c);
    endtask

    task automatic step(input bit rs, input bit c, input bit lt, input bit st);
        rst_n        = rs;
        bus.car      = c;
        bus.long_to  = lt;
        bus.short_to = st;
        @(posedge clk);
        model_edge(rs, c, lt, st);
        #1;
        chk("state", 8'(bus.state_dbg),  8'(m_phase));
        chk("hwy",   8'(bus.hwy_light),  8'(hwy_tab[m_phase]));
        chk("farm",  8'(bus.farm_light), 8'(farm_tab[m_phase]));
        chk("start", 8'(bus.tmr_start),  8'(m_start));
        chk("sel",   8'(bus.tmr_sel),    8'(m_sel));
        @(negedge clk);
    endtask

    initial begin
        bit c;
        bus.car = 0; bus.long_to = 0; bus.short_to = 0;
        @(negedge clk);

        // Reset and release
        step(0, 0, 0, 0); step(0, 0, 0, 0);
        chk("rst_state", 8'(bus.state_dbg), 8'd0);
        chk("rst_hwy",   8'(bus.hwy_light), 8'd2);
        chk("rst_start", 8'(bus.tmr_start), 8'd0);
        step(1, 0, 0, 0);
        chk("rel_start", 8'(bus.tmr_start), 8'd1);
        chk("rel_sel",   8'(bus.tmr_sel),   8'd0);
        step(1, 0, 0, 0);
        chk("rel_once",  8'(bus.tmr_start), 8'd0);
        step(1, 0, 1, 0);
        chk("rearm_state", 8'(bus.state_dbg), 8'd0);
        chk("rearm_start", 8'(bus.tmr_start), 8'd1);

        // Car request then highway yellow
        step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0);
        step(1, 0, 1, 0);
        chk("hy_state", 8'(bus.state_dbg), 8'd1);
        chk("hy_hwy",   8'(bus.hwy_light), 8'd1);
        chk("hy_sel",   8'(bus.tmr_sel),   8'd1);
        step(1, 0, 1, 0);
        chk("hy_ign_lt", 8'(bus.state_dbg), 8'd1);
        chk("hy_ign_st", 8'(bus.tmr_start), 8'd0);

        // All-red 1 lasts ALLRED+1 cycles, long_to ignored inside it
        step(1, 0, 0, 1);
        chk("ar1_state", 8'(bus.state_dbg), 8'd2);
        chk("ar1_start", 8'(bus.tmr_start), 8'd0);
        step(1, 0, 1, 0); step(1, 0, 0, 0); step(1, 0, 0, 0);
        chk("ar1_hold", 8'(bus.state_dbg), 8'd2);
        step(1, 0, 0, 0);
        chk("fg_state", 8'(bus.state_dbg),  8'd3);
        chk("fg_farm",  8'(bus.farm_light), 8'd2);
        chk("fg_start", 8'(bus.tmr_start),  8'd1);
        chk("fg_sel",   8'(bus.tmr_sel),    8'd0);

        // Farm green with car held high, then yellow and all-red 2
        step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0);
        step(1, 1, 1, 0);
        chk("fy_farm", 8'(bus.farm_light), 8'd1);
        chk("fy_sel",  8'(bus.tmr_sel),    8'd1);
        step(1, 1, 0, 1);
        chk("ar2_state", 8'(bus.state_dbg), 8'd5);
        step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("hg_back",  8'(bus.state_dbg), 8'd0);
        chk("hg_start", 8'(bus.tmr_start), 8'd1);
        step(1, 0, 0, 1);
        chk("hg_ign_st", 8'(bus.tmr_start), 8'd0);
        step(1, 0, 1, 0);
        chk("hy_again", 8'(bus.state_dbg), 8'd1);

        // Reset mid clearance count
        step(1, 0, 0, 1); step(1, 0, 0, 0); step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("mid_rst_state", 8'(bus.state_dbg), 8'd0);
        chk("mid_rst_hwy",   8'(bus.hwy_light), 8'd2);
        step(1, 0, 0, 0);
        chk("mid_rst_start", 8'(bus.tmr_start), 8'd1);

        // Random traffic
        c = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) c = ~c;
            step($urandom_range(0, 149) != 0, c,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/traffic_ctrl_fsm.md
Name: traffic_ctrl_fsm

Overview:
- Downstream consumer of the traffic-light timer. It turns the timer's long (green) and short (yellow) timeout pulses, plus the farm-road car sensor, into highway and farm-road light drives.
- Drives the timer's interval select and restart pulse back upstream, so the timer and this FSM form a closed loop.
- Inserts an internally counted all-red clearance interval between directions.
- Moore machine; all outputs registered.

Parameters:
- CNT_W, 26, width of the all-red clearance counter.
- ALLRED_CYC, 26'd24_999_999, all-red clearance lasts ALLRED_CYC+1 clk cycles (0.5 s at 50 MHz).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- car  input  1  raw asynchronous farm-road car sensor, level.
- long_to  input  1  single-cycle pulse from timer: green interval expired.
- short_to  input  1  single-cycle pulse from timer: yellow interval expired.
- tmr_sel  output  1  timer interval select: 0 = green/long, 1 = yellow/short.
- tmr_start  output  1  single-cycle pulse that restarts the timer with the interval on tmr_sel.
- hwy_light  output  2  highway lights: 2'b00 red, 2'b01 yellow, 2'b10 green.
- farm_light  output  2  farm-road lights, same encoding.
- state_dbg  output  3  current state code.

Behaviour:
- States (state_dbg): HG=0, HY=1, AR1=2, FG=3, FY=4, AR2=5. Codes 6 and 7 are illegal and go to HG on the next clock.
- Synchronous reset (rst_n=0 at a rising edge) sets:
  - state=HG, hwy_light=10, farm_light=00, tmr_sel=0, tmr_start=0;
  - req=0, clr_cnt=0, sync flops=0;
  - pending_start=1.
- Reset mid-operation behaves identically from any state, and aborts any clearance count.
- Car input: 2-flop synchronizer gives car_s (2-cycle latency).
  - Request latch req: set when car_s=1 in any state except FG; cleared on the transition into FG.
  - If set and clear coincide, clear wins.
- Light outputs per state (hwy/farm):
  - HG: 10/00
  - HY: 01/00
  - AR1 and AR2: 00/00
  - FG: 00/10
  - FY: 00/01
- Lights update in the same edge as the state register.
- Transitions:
  - HG: long_to=1 and req=1 -> HY. long_to=1 and req=0 -> stay in HG and re-arm the timer (tmr_start pulse, tmr_sel=0).
  - HY: short_to=1 -> AR1.
  - AR1: clr_cnt==ALLRED_CYC -> FG, clr_cnt<=0; otherwise clr_cnt increments.
  - FG: long_to=1 -> FY.
  - FY: short_to=1 -> AR2.
  - AR2: same counting rule as AR1, then -> HG.
- Timer handshake:
  - tmr_start is high for exactly one cycle, in the cycle after the state register enters HG, HY, FG or FY.
  - It also pulses in the first cycle after reset release (via pending_start) and on an HG re-arm.
  - tmr_sel updates together with tmr_start: 0 for HG/FG, 1 for HY/FY. It holds its value in AR states.
  - No tmr_start is issued when entering AR states.
- Timeouts that do not match the current state (long_to in HY/FY/AR, short_to in HG/FG/AR) are ignored.
  - If long_to and short_to arrive together, only the one matching the state is used.
- clr_cnt is CNT_W bits, counts 0..ALLRED_CYC, never wraps, and is held at 0 outside AR states.
- Illegal state recovery takes one cycle and issues a tmr_start pulse with tmr_sel=0.

Test Plan (ALLRED_CYC=3):
- Reset release with car=0 -> state_dbg=0, hwy=10, farm=00, a single tmr_start pulse with tmr_sel=0. After a long_to pulse -> remains HG with another tmr_start pulse.
- car=1 for 1 cycle, then long_to -> next cycle HY (hwy=01), tmr_start pulse with tmr_sel=1. Then short_to -> AR1 with both lights 00 for exactly 4 cycles, then FG (farm=10), tmr_start pulse with tmr_sel=0, req=0.
- In FG: long_to -> FY (farm=01, tmr_sel=1). Then short_to -> AR2 for 4 cycles, then HG with a tmr_start pulse.
- car held high throughout FG -> req stays 0 on FG entry (clear wins). After returning to HG, req=1 within 3 cycles, so the next long_to goes to HY.
- short_to in HG and long_to in HY or AR1 -> no state change, no tmr_start pulse.
- rst_n=0 for one edge during AR1 at clr_cnt=2 -> HG, hwy=10, clr_cnt=0, tmr_start pulse in the first cycle after release.
